// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops an async FIFO read port into a 2-entry skid buffer
// and presents the words as a valid/ready stream with burst framing and a word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EN,
  input  logic                  FLUSH,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic [CNT_WIDTH-1:0]  WORD_CNT,
  output logic                  BUSY,
  output logic [1:0]            DBG_OCC
);

  // Stream handshake: a word moves on every rising edge where OUT_VALID and OUT_READY
  // are both high and FLUSH is low; OUT_VALID never waits on OUT_READY, and OUT_DATA
  // stays fixed while OUT_VALID is high without OUT_READY.

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY0 = 2'd0,
    ONE    = 2'd1,
    TWO    = 2'd2
  } occ_t;

  occ_t                  occ, occ_next;
  logic                  head, head_next;
  logic                  tail;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] slot_q [2];
  logic [IDX_W-1:0]      burst_idx;

  // Pop strobe only looks at registered occupancy, never at OUT_READY.
  always_comb begin
    R_INC     = ~R_RST & EN & ~EMPTY & ~FLUSH & (occ != TWO);
    OUT_VALID = (occ != EMPTY0);
    BUSY      = (occ != EMPTY0);
    OUT_DATA  = slot_q[head];
    OUT_LAST  = OUT_VALID & (burst_idx == LAST_IDX);
    DBG_OCC   = occ;
    push      = R_INC;
    pop       = OUT_VALID & OUT_READY & ~FLUSH;
    tail      = (occ == ONE) ? ~head : head;
  end

  always_comb begin
    occ_next  = occ;
    head_next = head;
    if (FLUSH) begin
      occ_next = EMPTY0;
    end else begin
      case (occ)
        EMPTY0: if (push) occ_next = ONE;
        ONE: begin
          if (push && !pop)      occ_next = TWO;
          else if (!push && pop) occ_next = EMPTY0;
        end
        TWO:     if (pop) occ_next = ONE;
        default: occ_next = EMPTY0;
      endcase
      if (pop) head_next = ~head;
    end
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      occ  <= EMPTY0;
      head <= 1'b0;
    end else begin
      occ  <= occ_next;
      head <= head_next;
    end
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      burst_idx <= '0;
      WORD_CNT  <= '0;
    end else begin
      if (push) slot_q[tail] <= RD_DATA;
      if (FLUSH)    burst_idx <= '0;
      else if (pop) burst_idx <= OUT_LAST ? '0 : burst_idx + IDX_W'(1);
      if (pop) WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
    end
  end

endmodule
